pri_enc_rr: RTL
===============

// Module: pri_enc_rr
// PURPOSE
//  Parametrised N-to-log2(N) priority encoder with a registered output and valid/ready handshake.
//  Two selectable modes: fixed priority (highest index wins) or round-robin (rotating pointer).
//  Turns a level request vector (buttons, IRQ lines, FIFO-not-empty flags) into one index per cycle.
//  The index goes to a downstream consumer, e.g. a 7-seg display driver or a channel mux.
// PARAMETERS
//  N  16  number of request lines; power of two, 2..256
//  W  $clog2(N)  output index width; localparam, derived from N, not overridable
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous reset, active-low
//  enable     in   1  1 = new captures allowed; 0 = no capture, a pending grant is held
//  rr_mode    in   1  0 = fixed priority, 1 = round-robin
//  req        in   N  request vector, level sensitive, sampled every cycle
//  out_ready  in   1  consumer accepts out_idx this cycle
//  out_valid  out  1  out_idx holds a grant
//  out_idx    out  W  encoded index of the granted request
//  out_multi  out  1  more than one req bit was set at capture (only with PRI_ENC_MULTI_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async, immediate): out_valid=0, out_idx=0, out_multi=0, ptr=0.
//    A pending grant is discarded.
//  - One internal state register, ptr[W-1:0], holds the round-robin start position.
//  - Capture condition: enable & |req & (!out_valid | out_ready).
//    On capture, out_valid=1 on the next edge and out_idx holds the grant.
//    Latency is 1 cycle from req to out_valid.
//  - Hold: while out_valid & !out_ready, out_idx, out_multi and ptr stay stable.
//    req changes have no effect during the hold.
//  - Drain: out_valid & out_ready & no capture -> out_valid=0; out_idx keeps its last value.
//  - Back-to-back: accept and capture in the same cycle is allowed; full throughput, one grant/cycle.
//  - Fixed mode: grant = highest set bit of req; ptr is not modified.
//  - RR mode: masked = req & ~((1<<ptr)-1).
//    If masked != 0, grant = lowest set bit of masked; otherwise grant = lowest set bit of req.
//    On capture, ptr <= grant+1, wrapping modulo N (natural W-bit overflow).
//  - Mode switch: sampled at the capture cycle. ptr is retained across fixed-mode periods.
//  - req=0 or enable=0: no capture. A held grant still drains normally via out_ready.
//  - No combinational path from req or out_ready to any output.
// CONFIGURATION
//  PRI_ENC_MULTI_EN defined:
//    out_multi port exists and registers (req & (req-1)) != 0 at capture, held alongside out_idx.
//  PRI_ENC_MULTI_EN undefined:
//    out_multi port and its flop are absent. All other behaviour is identical.
// STRUCTURE
//  - Package pri_enc_pkg:
//    MODE_FIXED=1'b0 and MODE_RR=1'b1 constants; clog2 helper function.
//  - Sub-module pri_enc_find (combinational, parameter N):
//    lowest/highest set-bit finder with a found flag. Instanced for the masked, unmasked and highest searches.
//  - Top level: capture logic, ptr register, output registers.
// TESTING  (N=16)
//  1 Reset: assert rst_n=0 mid-grant -> out_valid=0, out_idx=0 immediately, with no clock edge.
//  2 Fixed, ready=1, enable=1: req=1<<k for k=0..15 -> out_idx=k one cycle later, out_multi=0.
//  3 Fixed: req=16'h4100 -> out_idx=14, out_multi=1; ptr unchanged (=0).
//  4 RR, ready=1: req=16'hFFFF held -> out_idx 0,1,...,15,0,1 on consecutive cycles, out_valid stays 1.
//  5 RR: req=16'h0101, ready=0 for 3 cycles -> out_idx=0 held stable, valid=1.
//    Then ready=1 -> next grant out_idx=8, then 0.
//  6 enable=0, req=16'h8000 -> out_valid stays 0. Drop enable while a grant is held -> grant kept until ready=1.
//  Scoreboard: a reference model checks every accepted grant; an assertion checks out_idx is stable while valid & !ready.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the pri_enc_rr priority encoder.
//   MODE_FIXED / MODE_RR : values of the rr_mode input
//   clog2()              : ceiling log2, used to size the index width from N
package pri_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 of v, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pri_enc_find.sv
// Combinational set-bit finder.
//   vec_i   : input vector (N bits)
//   idx_c   : index of the lowest (HIGHEST=0) or highest (HIGHEST=1) set bit
//   found_c : 1 when any bit of vec_i is set; idx_c is 0 otherwise
module pri_enc_find
  import pri_enc_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter bit          HIGHEST = 1'b0
) (
  input  logic [N-1:0]         vec_i,
  output logic [clog2(N)-1:0]  idx_c,
  output logic                 found_c
);

  localparam int unsigned W = clog2(N);

  // Upward scan: highest search keeps overwriting, lowest search keeps the first hit.
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i] && (HIGHEST || !found_c)) begin
        idx_c   = W'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_enc_rr.sv
// Priority encoder with fixed-priority or round-robin selection, a registered
// output and a valid/ready handshake. Optional out_multi flag under
// PRI_ENC_MULTI_EN.
//   clk, rst_n  : clock, async active-low reset
//   enable      : allow new captures (a held grant is kept when low)
//   rr_mode     : 0 = fixed (highest index wins), 1 = round-robin
//   req         : level request vector
//   out_ready   : consumer accepts the current grant
//   out_valid   : out_idx holds a grant
//   out_idx     : granted request index
//   out_multi   : more than one request was set at capture (PRI_ENC_MULTI_EN)
module pri_enc_rr
  import pri_enc_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                rr_mode,
  input  logic [N-1:0]        req,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [clog2(N)-1:0] out_idx
`ifdef PRI_ENC_MULTI_EN
  ,
  output logic                out_multi
`endif
);

  localparam int unsigned W = clog2(N);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;

  logic [N-1:0] masked;
  logic [W-1:0] m_idx, l_idx, h_idx, grant;
  logic         m_found, l_found, h_found, any_req, cap;

  // Requests at or above the round-robin pointer.
  assign masked = req & ~((N'(1) << ptr_q) - N'(1));

  pri_enc_find #(.N(N), .HIGHEST(1'b0)) u_find_masked (
    .vec_i   (masked),
    .idx_c   (m_idx),
    .found_c (m_found)
  );

  pri_enc_find #(.N(N), .HIGHEST(1'b0)) u_find_low (
    .vec_i   (req),
    .idx_c   (l_idx),
    .found_c (l_found)
  );

  pri_enc_find #(.N(N), .HIGHEST(1'b1)) u_find_high (
    .vec_i   (req),
    .idx_c   (h_idx),
    .found_c (h_found)
  );

  // Grant selection, capture decision and next-state.
  always_comb begin
    grant   = h_idx;
    any_req = h_found;
    if (rr_mode == MODE_RR) begin
      grant   = m_found ? m_idx : l_idx;
      any_req = l_found;
    end

    cap     = enable & any_req & (~valid_q | out_ready);

    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (cap) begin
      valid_d = 1'b1;
      idx_d   = grant;
      if (rr_mode == MODE_RR) ptr_d = grant + W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;

`ifdef PRI_ENC_MULTI_EN
  logic multi_q, multi_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    multi_d = multi_q;
    if (cap) multi_d = |(req & (req - N'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_q <= 1'b0;
    else        multi_q <= multi_d;
  end

  assign out_multi = multi_q;
`endif

endmodule
